// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard scoreboard: parameter defaults, the
// multiply/divide FSM state type and the per-register pending-counter width.
package hazard_pkg;

   localparam int NUM_REGS_DEF = 32;
   localparam int LOAD_LAT_DEF = 1;
   localparam int PEND_W       = 3;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mdu_state_t;

endpackage

// File: rtl/hazard_pend_counter.sv
// One architectural register's load-pending counter: a reload to LOAD_LAT
// wins over the countdown, and the count parks at zero.
module hazard_pend_counter
   import hazard_pkg::*;
#(
   parameter int LOAD_LAT = LOAD_LAT_DEF
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_reload,
   output logic o_pending
);

   localparam logic [PEND_W-1:0] RELOAD_VAL = PEND_W'(LOAD_LAT);

   logic [PEND_W-1:0] cnt_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_q <= '0;
      end else if (i_reload) begin
         cnt_q <= RELOAD_VAL;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign o_pending = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard unit: per-register load scoreboard plus a single
// outstanding mul/div tracker, producing stall/flush controls and counters.
module hazard_scoreboard_unit
   import hazard_pkg::*;
#(
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int LOAD_LAT = LOAD_LAT_DEF,
   parameter int CNT_W    = 16,
   localparam int AW      = $clog2(NUM_REGS)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic [AW-1:0] i_id_rs1_addr,
   input  logic [AW-1:0] i_id_rs2_addr,
   input  logic          i_id_rs1_used,
   input  logic          i_id_rs2_used,
   input  logic          i_id_is_mdu,
   input  logic          i_issue,
   input  logic [AW-1:0] i_issue_rd_addr,
   input  logic          i_issue_is_load,
   input  logic          i_issue_is_mdu,
   input  logic          i_mdu_done,
   input  logic          i_redirect,
   output logic          o_stall_pc,
   output logic          o_stall_if_id,
   output logic          o_flush_if_id,
   output logic          o_flush_id_ex,
   output logic          o_mdu_busy,
   output logic          o_mdu_state,
   output logic [CNT_W-1:0] o_stall_cnt,
   output logic [CNT_W-1:0] o_flush_cnt
);

   // Issue handshake: i_issue is the ID-stage request (valid), and the
   // instruction is accepted into EX only in a cycle where neither a stall
   // nor a redirect is present (ready = ~stall & ~i_redirect). A request
   // that is not accepted leaves all scoreboard state untouched.
   logic stall;
   logic eff_issue;
   logic load_issue;
   logic mdu_issue;

   assign eff_issue  = i_issue & ~stall & ~i_redirect;
   assign load_issue = eff_issue & i_issue_is_load;
   assign mdu_issue  = eff_issue & i_issue_is_mdu;

   logic [NUM_REGS-1:0] pend_vec;
   logic [NUM_REGS-1:0] reload_vec;

   // x0 is hardwired and can never be waited on.
   assign pend_vec[0]   = 1'b0;
   assign reload_vec[0] = 1'b0;

   generate
      for (genvar r = 1; r < NUM_REGS; r++) begin : g_pend
         assign reload_vec[r] = load_issue && (i_issue_rd_addr == AW'(r));

         hazard_pend_counter #(
            .LOAD_LAT (LOAD_LAT)
         ) u_pend_counter (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_reload  (reload_vec[r]),
            .o_pending (pend_vec[r])
         );
      end
   endgenerate

   mdu_state_t    state_q;
   mdu_state_t    state_d;
   logic [AW-1:0] mdu_rd_q;
   logic [AW-1:0] mdu_rd_d;
   logic          mdu_busy;

   assign mdu_busy = (state_q == BUSY);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= IDLE;
         mdu_rd_q <= '0;
      end else begin
         state_q  <= state_d;
         mdu_rd_q <= mdu_rd_d;
      end
   end

   // A new MDU op accepted in the same cycle the old one completes keeps the
   // unit busy, now tracking the newer destination.
   always_comb begin
      state_d  = state_q;
      mdu_rd_d = mdu_rd_q;
      case (state_q)
         IDLE: begin
            if (mdu_issue) begin
               state_d  = BUSY;
               mdu_rd_d = i_issue_rd_addr;
            end
         end
         BUSY: begin
            if (mdu_issue) begin
               state_d  = BUSY;
               mdu_rd_d = i_issue_rd_addr;
            end else if (i_mdu_done) begin
               state_d  = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   logic rs1_load_hz;
   logic rs2_load_hz;
   logic rs1_mdu_hz;
   logic rs2_mdu_hz;
   logic data_hz;
   logic struct_hz;

   assign rs1_load_hz = i_id_rs1_used & pend_vec[i_id_rs1_addr];
   assign rs2_load_hz = i_id_rs2_used & pend_vec[i_id_rs2_addr];
   assign rs1_mdu_hz  = i_id_rs1_used & (i_id_rs1_addr == mdu_rd_q);
   assign rs2_mdu_hz  = i_id_rs2_used & (i_id_rs2_addr == mdu_rd_q);

   assign data_hz   = rs1_load_hz | rs2_load_hz |
                      (mdu_busy & (mdu_rd_q != '0) & (rs1_mdu_hz | rs2_mdu_hz));
   assign struct_hz = i_id_is_mdu & mdu_busy & ~i_mdu_done;

   // The redirect squashes the ID instruction anyway, so holding it is moot.
   assign stall = (data_hz | struct_hz) & ~i_redirect & ~i_rst;

   assign o_stall_pc    = stall;
   assign o_stall_if_id = stall;
   assign o_flush_if_id = i_redirect;
   assign o_flush_id_ex = (i_redirect & ~i_rst) | stall;
   assign o_mdu_busy    = mdu_busy;
   assign o_mdu_state   = state_q;

   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
         end
         if (i_redirect && (flush_cnt_q != '1)) begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
         end
      end
   end

   assign o_stall_cnt = stall_cnt_q;
   assign o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit: instance 0 uses LOAD_LAT=1,
// instance 1 LOAD_LAT=3; both have 4-bit counters so saturation is reachable.
module tb_hazard_scoreboard_unit;

   typedef struct packed {
      logic       rst;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       rs1_used;
      logic       rs2_used;
      logic       id_mdu;
      logic       issue;
      logic [4:0] rd;
      logic       is_load;
      logic       is_mdu;
      logic       done;
      logic       redirect;
   } in_t;

   localparam in_t IDLE_V = '0;

   // {stall_pc, stall_if_id, flush_if_id, flush_id_ex, mdu_busy}
   localparam logic [4:0] C_NONE    = 5'b00000;
   localparam logic [4:0] C_STALL   = 5'b11010;
   localparam logic [4:0] C_REDIR   = 5'b00110;
   localparam logic [4:0] C_BUSY    = 5'b00001;
   localparam logic [4:0] C_STALL_B = 5'b11011;
   localparam logic [4:0] C_RSTR    = 5'b00100;

   logic clk;
   in_t  in_v [2];

   logic       stall_pc    [2];
   logic       stall_if_id [2];
   logic       flush_if_id [2];
   logic       flush_id_ex [2];
   logic       mdu_busy    [2];
   logic       mdu_state   [2];
   logic [3:0] stall_cnt   [2];
   logic [3:0] flush_cnt   [2];

   // tag[21:14] inst[13] ctrl[12:8] stall_cnt[7:4] flush_cnt[3:0]
   logic [21:0] exp_q[$];
   int          n_checks;
   int          n_errors;
   int          sc_m [2];
   int          fc_m [2];

   // clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   generate
      for (genvar g = 0; g < 2; g++) begin : g_dut
         hazard_scoreboard_unit #(
            .NUM_REGS (32),
            .LOAD_LAT ((g == 0) ? 1 : 3),
            .CNT_W    (4)
         ) u_dut (
            .i_clk           (clk),
            .i_rst           (in_v[g].rst),
            .i_id_rs1_addr   (in_v[g].rs1),
            .i_id_rs2_addr   (in_v[g].rs2),
            .i_id_rs1_used   (in_v[g].rs1_used),
            .i_id_rs2_used   (in_v[g].rs2_used),
            .i_id_is_mdu     (in_v[g].id_mdu),
            .i_issue         (in_v[g].issue),
            .i_issue_rd_addr (in_v[g].rd),
            .i_issue_is_load (in_v[g].is_load),
            .i_issue_is_mdu  (in_v[g].is_mdu),
            .i_mdu_done      (in_v[g].done),
            .i_redirect      (in_v[g].redirect),
            .o_stall_pc      (stall_pc[g]),
            .o_stall_if_id   (stall_if_id[g]),
            .o_flush_if_id   (flush_if_id[g]),
            .o_flush_id_ex   (flush_id_ex[g]),
            .o_mdu_busy      (mdu_busy[g]),
            .o_mdu_state     (mdu_state[g]),
            .o_stall_cnt     (stall_cnt[g]),
            .o_flush_cnt     (flush_cnt[g])
         );
      end
   endgenerate

   // driver tasks
   function automatic in_t f_load(input logic [4:0] rd);
      in_t v;
      v         = IDLE_V;
      v.issue   = 1'b1;
      v.is_load = 1'b1;
      v.rd      = rd;
      return v;
   endfunction

   function automatic in_t f_mdu(input logic [4:0] rd);
      in_t v;
      v        = IDLE_V;
      v.issue  = 1'b1;
      v.is_mdu = 1'b1;
      v.rd     = rd;
      return v;
   endfunction

   function automatic in_t f_use(input logic [4:0] rs1, input logic u1,
                                 input logic [4:0] rs2, input logic u2,
                                 input logic issue);
      in_t v;
      v          = IDLE_V;
      v.rs1      = rs1;
      v.rs1_used = u1;
      v.rs2      = rs2;
      v.rs2_used = u2;
      v.issue    = issue;
      v.rd       = 5'd1;
      return v;
   endfunction

   // Apply one cycle of stimulus to instance k and queue its expected outputs.
   task automatic step(input int k, input in_t v, input logic [4:0] ec,
                       input logic [7:0] tag);
      logic kb;
      kb = k[0];
      @(posedge clk);
      #1;
      in_v[k]     = v;
      in_v[1 - k] = IDLE_V;
      if (v.rst) begin
         sc_m[k] = 0;
         fc_m[k] = 0;
      end
      exp_q.push_back({tag, kb, ec, 4'(sc_m[k]), 4'(fc_m[k])});
      if (!v.rst) begin
         if (ec[4] && sc_m[k] < 15) sc_m[k]++;
         if (v.redirect && fc_m[k] < 15) fc_m[k]++;
      end
   endtask

   // scoreboard monitor
   logic [21:0] e;
   int          mk;
   logic [4:0]  got_ctrl;

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         e  = exp_q.pop_front();
         mk = e[13] ? 1 : 0;
         got_ctrl = {stall_pc[mk], stall_if_id[mk], flush_if_id[mk],
                     flush_id_ex[mk], mdu_busy[mk]};
         n_checks++;
         if (got_ctrl !== e[12:8]) begin
            n_errors++;
            $display("FAIL ctrl tag=%0d inst=%0d got=%b exp=%b", e[21:14], mk, got_ctrl, e[12:8]);
         end
         n_checks++;
         if (stall_cnt[mk] !== e[7:4]) begin
            n_errors++;
            $display("FAIL stall_cnt tag=%0d inst=%0d got=%0d exp=%0d", e[21:14], mk, stall_cnt[mk], e[7:4]);
         end
         n_checks++;
         if (flush_cnt[mk] !== e[3:0]) begin
            n_errors++;
            $display("FAIL flush_cnt tag=%0d inst=%0d got=%0d exp=%0d", e[21:14], mk, flush_cnt[mk], e[3:0]);
         end
      end
   end

   // stimulus
   initial begin
      in_t v;
      n_checks = 0;
      n_errors = 0;
      sc_m     = '{0, 0};
      fc_m     = '{0, 0};
      v        = IDLE_V;
      v.rst    = 1'b1;
      in_v[0]  = v;
      in_v[1]  = v;
      repeat (2) @(posedge clk);

      // reset state: only flush_if_id follows redirect
      v = IDLE_V; v.rst = 1'b1; v.redirect = 1'b1;
      step(0, v, C_RSTR, 8'd1);
      step(1, v, C_RSTR, 8'd2);

      // LOAD_LAT=1: single-bubble load-use
      step(0, f_load(5'd5), C_NONE, 8'd3);
      step(0, f_use(5'd5, 1'b1, 5'd0, 1'b0, 1'b1), C_STALL, 8'd4);
      step(0, f_use(5'd5, 1'b1, 5'd0, 1'b0, 1'b1), C_NONE, 8'd5);
      // x0 is never pending; unused rs2 does not stall
      step(0, f_load(5'd0), C_NONE, 8'd6);
      step(0, f_use(5'd0, 1'b1, 5'd0, 1'b1, 1'b1), C_NONE, 8'd7);
      step(0, f_load(5'd5), C_NONE, 8'd8);
      step(0, f_use(5'd3, 1'b1, 5'd5, 1'b0, 1'b1), C_NONE, 8'd9);
      step(0, f_load(5'd5), C_NONE, 8'd10);
      step(0, f_use(5'd3, 1'b1, 5'd5, 1'b1, 1'b1), C_STALL, 8'd11);
      step(0, f_use(5'd3, 1'b1, 5'd5, 1'b1, 1'b1), C_NONE, 8'd12);
      // redirect over a stall: no stall, both flushes, issue ignored
      step(0, f_load(5'd8), C_NONE, 8'd13);
      v = f_load(5'd9); v.rs1 = 5'd8; v.rs1_used = 1'b1; v.redirect = 1'b1;
      step(0, v, C_REDIR, 8'd14);
      step(0, f_use(5'd9, 1'b1, 5'd8, 1'b1, 1'b0), C_NONE, 8'd15);
      // flush counter saturation
      for (int i = 0; i < 17; i++) begin
         v = IDLE_V; v.redirect = 1'b1;
         step(0, v, C_REDIR, 8'(16 + i));
      end
      step(0, IDLE_V, C_NONE, 8'd33);

      // LOAD_LAT=3: three stall cycles then release
      step(1, f_load(5'd7), C_NONE, 8'd40);
      for (int i = 0; i < 3; i++) begin
         step(1, f_use(5'd7, 1'b1, 5'd0, 1'b0, 1'b1), C_STALL, 8'(41 + i));
      end
      step(1, f_use(5'd7, 1'b1, 5'd0, 1'b0, 1'b1), C_NONE, 8'd44);

      // MDU: dependent and structural stalls until done
      step(1, f_mdu(5'd9), C_NONE, 8'd50);
      step(1, f_use(5'd9, 1'b1, 5'd0, 1'b0, 1'b1), C_STALL_B, 8'd51);
      step(1, f_use(5'd9, 1'b1, 5'd0, 1'b0, 1'b1), C_STALL_B, 8'd52);
      v = f_mdu(5'd10); v.id_mdu = 1'b1;
      step(1, v, C_STALL_B, 8'd53);
      v.done = 1'b1;
      step(1, v, C_BUSY, 8'd54);
      step(1, f_use(5'd9, 1'b1, 5'd0, 1'b0, 1'b0), C_BUSY, 8'd55);
      step(1, f_use(5'd0, 1'b0, 5'd10, 1'b1, 1'b0), C_STALL_B, 8'd56);
      v = f_use(5'd0, 1'b0, 5'd10, 1'b1, 1'b0); v.done = 1'b1;
      step(1, v, C_STALL_B, 8'd57);
      step(1, f_use(5'd0, 1'b0, 5'd10, 1'b1, 1'b0), C_NONE, 8'd58);
      v = IDLE_V; v.done = 1'b1;
      step(1, v, C_NONE, 8'd59);
      step(1, IDLE_V, C_NONE, 8'd60);

      // reset mid-stall abandons the load and the MDU op
      step(1, f_mdu(5'd12), C_NONE, 8'd70);
      step(1, f_load(5'd7), C_BUSY, 8'd71);
      step(1, f_use(5'd7, 1'b1, 5'd0, 1'b0, 1'b1), C_STALL_B, 8'd72);
      step(1, f_use(5'd7, 1'b1, 5'd0, 1'b0, 1'b1), C_STALL_B, 8'd73);
      v = f_use(5'd7, 1'b1, 5'd0, 1'b0, 1'b1); v.rst = 1'b1;
      step(1, v, C_NONE, 8'd74);
      v = f_use(5'd7, 1'b1, 5'd12, 1'b1, 1'b0); v.id_mdu = 1'b1;
      step(1, v, C_NONE, 8'd75);
      step(1, v, C_NONE, 8'd76);

      repeat (3) @(posedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain got=%0d pending entries exp=0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
